data_memory_responder: RTL and testbench

Responder end of the core's instruction and data memory interfaces: a word-addressed unified RAM serving the CPU's combinational instruction fetch and data load/store ports. Owns a program-load front end (valid/ready) that fills memory while it holds the CPU in reset, then releases the CPU. Flags illegal accesses. Optionally exposes memory-mapped cycle-counter and status registers. Sits beside the CPU at top level; its outputs drive the CPU's memory read-value inputs and the CPU's `nreset`.

---
 rtl/data_memory_responder.sv | 130 +++++++++++++
 tb/tb_data_memory_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Unified instruction/data RAM responder with a program loader that holds the CPU in reset until the image is in.
// Optional memory-mapped cycle counter and status register are built when MEM_MMIO_EN is defined.
module data_memory_responder #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    input  logic                  clk_en_i,
    input  logic                  load_valid_i,
    output logic                  load_ready_o,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
    input  logic [31:0]           load_data_i,
    input  logic                  load_last_i,
    output logic                  cpu_nreset_o,
    input  logic [31:0]           instruction_memory_a_i,
    input  logic                  instruction_memory_en_i,
    output logic [31:0]           instruction_memory_v_o,
    input  logic [31:0]           data_memory_a_i,
    input  logic [31:0]           data_memory_out_v_i,
    input  logic                  data_memory_read_i,
    input  logic                  data_memory_write_i,
    output logic [31:0]           data_memory_in_v_o,
    output logic                  bus_error_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // state | meaning
    // LOAD  | loader owns memory, CPU held in reset
    // RUN   | CPU released, loader ignored
    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t state_q, state_d;
    logic   bus_error_q, bus_error_d;
    logic [31:0] mem [DEPTH];

    logic run, ld_acc, mem_we, acc_err, f_legal, d_legal, d_mmio;
    logic [ADDR_WIDTH-1:0] f_idx, d_idx;

    function automatic logic addr_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:ADDR_WIDTH+2] == '0);
    endfunction

    assign run     = (state_q == ST_RUN);
    assign f_legal = addr_legal(instruction_memory_a_i);
    assign d_legal = addr_legal(data_memory_a_i);
    assign f_idx   = instruction_memory_a_i[ADDR_WIDTH+1:2];
    assign d_idx   = data_memory_a_i[ADDR_WIDTH+1:2];

    assign load_ready_o = (state_q == ST_LOAD) && nreset_i;
    assign cpu_nreset_o = run;
    assign bus_error_o  = bus_error_q;
    assign ld_acc       = clk_en_i && load_valid_i && load_ready_o;
    assign mem_we       = clk_en_i && nreset_i && run && data_memory_write_i && d_legal;

`ifdef MEM_MMIO_EN
    logic [31:0] cnt_q, cnt_d;
    logic        hit_cnt, hit_stat, stat_clr;

    assign hit_cnt  = run && (data_memory_a_i == MMIO_BASE);
    assign hit_stat = run && (data_memory_a_i == MMIO_BASE + 32'd4);
    assign d_mmio   = hit_cnt || hit_stat;
    assign stat_clr = clk_en_i && hit_stat && data_memory_write_i && data_memory_out_v_i[0];

    always_comb begin
        cnt_d = cnt_q;
        if (clk_en_i && run) begin
            if (hit_cnt && data_memory_write_i) cnt_d = data_memory_out_v_i;
            else                                cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) cnt_q <= '0;
        else           cnt_q <= cnt_d;
    end
`else
    assign d_mmio = 1'b0;
`endif

    // Fetches never hit the MMIO window, so only the data port may use it.
    assign acc_err = clk_en_i && run &&
                     (((data_memory_read_i || data_memory_write_i) && !d_legal && !d_mmio) ||
                      (instruction_memory_en_i && !f_legal));

    always_comb begin
        instruction_memory_v_o = '0;
        if (instruction_memory_en_i && f_legal) instruction_memory_v_o = mem[f_idx];

        data_memory_in_v_o = '0;
        if (data_memory_read_i) begin
            if (d_legal) data_memory_in_v_o = mem[d_idx];
`ifdef MEM_MMIO_EN
            else if (hit_cnt)  data_memory_in_v_o = cnt_q;
            else if (hit_stat) data_memory_in_v_o = {31'b0, bus_error_q};
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_LOAD && ld_acc && load_last_i) state_d = ST_RUN;

        bus_error_d = bus_error_q;
`ifdef MEM_MMIO_EN
        if (stat_clr)     bus_error_d = 1'b0;
        else if (acc_err) bus_error_d = 1'b1;
`else
        if (acc_err) bus_error_d = 1'b1;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            state_q     <= ST_LOAD;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Array has no reset so a loaded image survives a CPU reset.
    always_ff @(posedge clk_i) begin
        if (ld_acc)      mem[load_addr_i] <= load_data_i;
        else if (mem_we) mem[d_idx]       <= data_memory_out_v_i;
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: load, release, store/load, illegal access, clk_en freeze, MMIO.
module tb_data_memory_responder;

    localparam int          AW   = 10;
    localparam logic [31:0] MMIO = 32'hFFFF_FF00;

    logic          clk_i = 1'b0;
    logic          nreset_i, clk_en_i, load_valid_i, load_last_i;
    logic          load_ready_o, cpu_nreset_o, bus_error_o;
    logic [AW-1:0] load_addr_i;
    logic [31:0]   load_data_i;
    logic [31:0]   instruction_memory_a_i, instruction_memory_v_o;
    logic          instruction_memory_en_i;
    logic [31:0]   data_memory_a_i, data_memory_out_v_i, data_memory_in_v_o;
    logic          data_memory_read_i, data_memory_write_i;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_q [$];
    logic [31:0] model [int];

    data_memory_responder #(.ADDR_WIDTH(AW), .MMIO_BASE(MMIO)) dut (
        .clk_i                   (clk_i),
        .nreset_i                (nreset_i),
        .clk_en_i                (clk_en_i),
        .load_valid_i            (load_valid_i),
        .load_ready_o            (load_ready_o),
        .load_addr_i             (load_addr_i),
        .load_data_i             (load_data_i),
        .load_last_i             (load_last_i),
        .cpu_nreset_o            (cpu_nreset_o),
        .instruction_memory_a_i  (instruction_memory_a_i),
        .instruction_memory_en_i (instruction_memory_en_i),
        .instruction_memory_v_o  (instruction_memory_v_o),
        .data_memory_a_i         (data_memory_a_i),
        .data_memory_out_v_i     (data_memory_out_v_i),
        .data_memory_read_i      (data_memory_read_i),
        .data_memory_write_i     (data_memory_write_i),
        .data_memory_in_v_o      (data_memory_in_v_o),
        .bus_error_o             (bus_error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic sb_push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input string tag, input logic [31:0] got);
        if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        else chk(tag, got, exp_q.pop_front());
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_beat(input int addr, input logic [31:0] data, input logic last);
        load_valid_i = 1'b1;
        load_addr_i  = addr[AW-1:0];
        load_data_i  = data;
        load_last_i  = last;
        tick();
        model[addr]  = data;
        load_valid_i = 1'b0;
        load_last_i  = 1'b0;
    endtask

    task automatic fetch_check(input string tag, input logic [31:0] a);
        instruction_memory_en_i = 1'b1;
        instruction_memory_a_i  = a;
        sb_push(model[int'(a >> 2)]);
        #1;
        sb_check(tag, instruction_memory_v_o);
        instruction_memory_en_i = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        data_memory_read_i = 1'b1;
        data_memory_a_i    = a;
        sb_push(exp);
        #1;
        sb_check(tag, data_memory_in_v_o);
    endtask

    initial begin
        nreset_i = 1'b0; clk_en_i = 1'b1;
        load_valid_i = 1'b0; load_last_i = 1'b0; load_addr_i = '0; load_data_i = '0;
        instruction_memory_a_i = '0; instruction_memory_en_i = 1'b0;
        data_memory_a_i = '0; data_memory_out_v_i = '0;
        data_memory_read_i = 1'b0; data_memory_write_i = 1'b0;
        repeat (2) tick();
        chk("rst_cpu_nreset", {31'b0, cpu_nreset_o}, 32'd0);
        chk("rst_load_ready", {31'b0, load_ready_o}, 32'd0);
        chk("rst_bus_error",  {31'b0, bus_error_o},  32'd0);
        nreset_i = 1'b1;
        #1;
        chk("load_ready_up", {31'b0, load_ready_o}, 32'd1);

        // CPU strobes during LOAD must be ignored, illegal or not.
        data_memory_write_i = 1'b1; data_memory_a_i = 32'h41; data_memory_out_v_i = 32'h0;
        load_beat(16, 32'h1234_5678, 1'b0);
        data_memory_a_i = 32'h40; data_memory_out_v_i = 32'h55;
        load_beat(0, 32'h11, 1'b0);
        data_memory_write_i = 1'b0;
        load_beat(1, 32'h22, 1'b0);
        load_beat(2, 32'hAA, 1'b0);
        chk("load_strobe_no_err", {31'b0, bus_error_o}, 32'd0);

        // Final beat presented while clk_en is low.
        load_valid_i = 1'b1; load_addr_i = 2; load_data_i = 32'h33; load_last_i = 1'b1;
        clk_en_i = 1'b0;
        repeat (5) tick();
        chk("freeze_cpu_nreset", {31'b0, cpu_nreset_o}, 32'd0);
        chk("freeze_load_ready", {31'b0, load_ready_o}, 32'd1);
        fetch_check("freeze_no_write", 32'd8);
        clk_en_i = 1'b1;
        tick();
        model[2] = 32'h33;
        load_valid_i = 1'b0; load_last_i = 1'b0;
        chk("run_cpu_nreset", {31'b0, cpu_nreset_o}, 32'd1);
        chk("run_load_ready", {31'b0, load_ready_o}, 32'd0);
        fetch_check("fetch_w2", 32'd8);
        fetch_check("fetch_w0", 32'd0);
        fetch_check("fetch_w1", 32'd4);
        #1;
        chk("fetch_disabled", instruction_memory_v_o, 32'd0);

        // Same-cycle read sees pre-write data; next cycle sees the store.
        data_memory_write_i = 1'b1; data_memory_out_v_i = 32'hDEAD_BEEF;
        read_check("rdw_old", 32'h40, model[16]);
        tick();
        model[16] = 32'hDEAD_BEEF;
        data_memory_write_i = 1'b0;
        read_check("rdw_new", 32'h40, model[16]);
        chk("store_no_err", {31'b0, bus_error_o}, 32'd0);
        data_memory_read_i = 1'b0;

        data_memory_write_i = 1'b1; data_memory_a_i = 32'h41; data_memory_out_v_i = 32'h0;
        tick();
        data_memory_write_i = 1'b0;
        chk("misalign_err", {31'b0, bus_error_o}, 32'd1);
        read_check("misalign_unchanged", 32'h40, model[16]);
        data_memory_read_i = 1'b0;
        repeat (2) tick();
        chk("err_sticky", {31'b0, bus_error_o}, 32'd1);

        // Reset mid-run: back to LOAD, memory retained.
        nreset_i = 1'b0;
        tick();
        chk("rst2_bus_error",  {31'b0, bus_error_o},  32'd0);
        chk("rst2_cpu_nreset", {31'b0, cpu_nreset_o}, 32'd0);
        nreset_i = 1'b1;
        load_beat(3, 32'h44, 1'b1);
        chk("rel2_cpu_nreset", {31'b0, cpu_nreset_o}, 32'd1);
        read_check("retained", 32'h40, model[16]);
        fetch_check("fetch_w3", 32'd12);
        read_check("oor_read_zero", 32'd1 << (AW + 2), 32'd0);
        tick();
        data_memory_read_i = 1'b0;
        chk("oor_err", {31'b0, bus_error_o}, 32'd1);

`ifdef MEM_MMIO_EN
        data_memory_write_i = 1'b1; data_memory_a_i = MMIO + 32'd4; data_memory_out_v_i = 32'd1;
        tick();
        data_memory_write_i = 1'b0;
        chk("stat_clear", {31'b0, bus_error_o}, 32'd0);
        read_check("stat_read", MMIO + 32'd4, 32'd0);
        data_memory_read_i = 1'b0;

        data_memory_write_i = 1'b1; data_memory_a_i = MMIO; data_memory_out_v_i = 32'hFFFF_FFFE;
        tick();
        data_memory_write_i = 1'b0;
        read_check("cnt_loaded", MMIO, 32'hFFFF_FFFE);
        tick();
        read_check("cnt_inc", MMIO, 32'hFFFF_FFFF);
        tick();
        read_check("cnt_wrap", MMIO, 32'd0);
        data_memory_read_i = 1'b0;
        chk("mmio_no_err", {31'b0, bus_error_o}, 32'd0);

        instruction_memory_en_i = 1'b1; instruction_memory_a_i = MMIO;
        sb_push(32'd0);
        #1;
        sb_check("mmio_fetch_zero", instruction_memory_v_o);
        tick();
        chk("mmio_fetch_err", {31'b0, bus_error_o}, 32'd1);
        // Clear and a fresh fetch error in the same cycle: clear wins.
        data_memory_write_i = 1'b1; data_memory_a_i = MMIO + 32'd4; data_memory_out_v_i = 32'd1;
        tick();
        data_memory_write_i = 1'b0; instruction_memory_en_i = 1'b0;
        chk("clear_wins", {31'b0, bus_error_o}, 32'd0);
`else
        nreset_i = 1'b0;
        tick();
        nreset_i = 1'b1;
        load_beat(4, 32'h55, 1'b1);
        chk("pre_mmio_err", {31'b0, bus_error_o}, 32'd0);
        read_check("mmio_absent_zero", MMIO, 32'd0);
        tick();
        data_memory_read_i = 1'b0;
        chk("mmio_absent_err", {31'b0, bus_error_o}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
